muldiv_sequencer: RTL

Multi-cycle sequencer for the CPU's unsigned 16-bit multiply and divide operations. It accepts a mul/div request from the execute stage, runs a shift-add multiplier or a restoring divider for WIDTH iterations, and holds the core with a stall signal until the result is ready. On completion it presents a full-width product, or a quotient and remainder, for write-back.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/muldiv_step.sv | 19 +
 rtl/muldiv_sequencer.sv | 68 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU op codes, sequencer states and default data width shared by the mul/div unit.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration, purely combinational.
module muldiv_step import cpu_pkg::*; #(
    parameter int W = DATA_W
) (
    input  logic         div,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] operand,
    output logic [W-1:0] hi_n,
    output logic [W-1:0] lo_n
);
    logic [W:0] sum, sh, diff;
    assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    assign sh   = {hi, lo[W-1]};
    // remainder < divisor keeps the shifted value below 2*divisor, so diff's top bit is the sign
    assign diff = sh - {1'b0, operand};
    assign hi_n = div ? (diff[W] ? sh[W-1:0] : diff[W-1:0]) : sum[W:1];
    assign lo_n = div ? {lo[W-2:0], ~diff[W]} : {sum[0], lo[W-1:1]};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned mul/div unit that stalls the core until the result is ready.
module muldiv_sequencer import cpu_pkg::*; #(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    seq_state_t state, next;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, opnd, hi_n, lo_n;
    logic op_div, is_div, accept, zero_div, last;
    assign is_div   = alu_ctr == ALU_DIV;
    assign accept   = state == IDLE && start && (alu_ctr == ALU_MUL || is_div);
    assign zero_div = is_div && b == '0;
    assign last     = cnt == CW'(WIDTH - 1);
    assign stall    = accept || state == RUN;
    assign result_lo = lo;
    assign result_hi = hi;
    muldiv_step #(.W(WIDTH)) u_step (
        .div(op_div), .hi(hi), .lo(lo), .operand(opnd), .hi_n(hi_n), .lo_n(lo_n)
    );
    always_comb begin
        next = state;
        next = state == IDLE ? (accept ? (zero_div ? DONE : RUN) : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            opnd <= '0;
            op_div <= 1'b0;
            div_by_zero <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= next;
            busy <= next == RUN;
            done <= next == DONE;
            if (accept) begin
                cnt <= '0;
                op_div <= is_div;
                opnd <= is_div ? b : a;
                div_by_zero <= zero_div;
                hi <= zero_div ? a : '0;
                lo <= zero_div ? '1 : (is_div ? a : b);
            end else if (state == RUN) begin
                hi <= hi_n;
                lo <= lo_n;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
